// File: rtl/qs_sort_core.sv
`default_nettype none
// ============================================================================
// Module   : qs_sort_core
// Purpose  : Load pLEN words, sort them in place with odd-even transposition,
//            then stream them out in ascending order through one strobe.
//            Define QS_SIGNED_EN for two's-complement ordering.
// Revision : 1.0  initial release
// ============================================================================
module qs_sort_core #(
    parameter int pDATA_WIDTH = 32,
    parameter int pLEN        = 10
) (
    input  logic                   wbs_clk_i,
    input  logic                   wbs_rst_i,
    input  logic                   start_fg,
    input  logic [pDATA_WIDTH-1:0] QS_data_in,
    input  logic                   QS_data_en,
    output logic [pDATA_WIDTH-1:0] QS_data_out,
    output logic                   idle_fg,
    output logic                   done_fg,
    output logic                   DIR_fg,
    output logic                   DOR_fg
);

    localparam int            CW   = $clog2(pLEN) + 1;
    localparam int            IW   = $clog2(pLEN);
    localparam logic [CW-1:0] LAST = CW'(pLEN - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SORT = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]            pass_cnt_q, pass_cnt_d;
    logic [CW-1:0]            rd_cnt_q, rd_cnt_d;
    logic                     done_q, done_d;
    logic                     idle_q, idle_d;
    logic                     dir_q, dir_d;
    logic                     dor_q, dor_d;
    logic [pDATA_WIDTH-1:0]   arr_q [pLEN];
    logic [pDATA_WIDTH-1:0]   arr_d [pLEN];

    // w_gt[k]: element k must move above element k+1 (strict, so ties stay put)
    logic [pLEN-2:0]          w_gt;
    logic [pDATA_WIDTH-1:0]   w_pass [pLEN];

    for (genvar g = 0; g < pLEN - 1; g++) begin : g_cmp
`ifdef QS_SIGNED_EN
        assign w_gt[g] = $signed(arr_q[g]) > $signed(arr_q[g+1]);
`else
        assign w_gt[g] = arr_q[g] > arr_q[g+1];
`endif
    end

    // Result of one transposition pass; pair (k,k+1) is active when k's parity
    // matches the pass parity, and active pairs never overlap.
    for (genvar k = 0; k < pLEN; k++) begin : g_elem
        localparam logic PAR_UP = ((k % 2) == 1);
        localparam logic PAR_DN = (((k + 1) % 2) == 1);
        logic                   take_up;
        logic                   take_dn;
        logic [pDATA_WIDTH-1:0] up_v;
        logic [pDATA_WIDTH-1:0] dn_v;

        if (k < pLEN - 1) begin : g_up
            assign take_up = (pass_cnt_q[0] == PAR_UP) && w_gt[k];
            assign up_v    = arr_q[k+1];
        end else begin : g_up_none
            assign take_up = 1'b0;
            assign up_v    = '0;
        end

        if (k > 0) begin : g_dn
            assign take_dn = (pass_cnt_q[0] == PAR_DN) && w_gt[k-1];
            assign dn_v    = arr_q[k-1];
        end else begin : g_dn_none
            assign take_dn = 1'b0;
            assign dn_v    = '0;
        end

        assign w_pass[k] = take_up ? up_v : (take_dn ? dn_v : arr_q[k]);
    end

    always_comb begin
        state_d    = state_q;
        wr_cnt_d   = wr_cnt_q;
        pass_cnt_d = pass_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        done_d     = done_q;
        arr_d      = arr_q;

        case (state_q)
            S_IDLE: begin
                if (start_fg) begin
                    state_d  = S_LOAD;
                    wr_cnt_d = '0;
                    done_d   = 1'b0;
                end
            end
            S_LOAD: begin
                if (QS_data_en) begin
                    arr_d[wr_cnt_q[IW-1:0]] = QS_data_in;
                    wr_cnt_d                = wr_cnt_q + ONE;
                    if (wr_cnt_q == LAST) begin
                        state_d    = S_SORT;
                        pass_cnt_d = '0;
                    end
                end
            end
            S_SORT: begin
                arr_d      = w_pass;
                pass_cnt_d = pass_cnt_q + ONE;
                if (pass_cnt_q == LAST) begin
                    state_d  = S_OUT;
                    rd_cnt_d = '0;
                end
            end
            S_OUT: begin
                if (QS_data_en) begin
                    if (rd_cnt_q == LAST) begin
                        state_d  = S_IDLE;
                        done_d   = 1'b1;
                        rd_cnt_d = '0;
                    end else begin
                        rd_cnt_d = rd_cnt_q + ONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Flags trail the state register by one cycle.
    always_comb begin
        idle_d = (state_q == S_IDLE);
        dir_d  = (state_q == S_LOAD);
        dor_d  = (state_q == S_OUT);
    end

    always_ff @(posedge wbs_clk_i or posedge wbs_rst_i) begin
        if (wbs_rst_i) begin
            state_q    <= S_IDLE;
            wr_cnt_q   <= '0;
            pass_cnt_q <= '0;
            rd_cnt_q   <= '0;
            done_q     <= 1'b0;
            idle_q     <= 1'b1;
            dir_q      <= 1'b0;
            dor_q      <= 1'b0;
            arr_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            pass_cnt_q <= pass_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            done_q     <= done_d;
            idle_q     <= idle_d;
            dir_q      <= dir_d;
            dor_q      <= dor_d;
            arr_q      <= arr_d;
        end
    end

    assign QS_data_out = dor_q ? arr_q[rd_cnt_q[IW-1:0]] : '0;
    assign idle_fg     = idle_q;
    assign done_fg     = done_q;
    assign DIR_fg      = dir_q;
    assign DOR_fg      = dor_q;

endmodule
`default_nettype wire

// File: tb/tb_qs_sort_core.sv
`default_nettype none
// Randomised scoreboard bench for qs_sort_core: expected sorted streams are
// queued at issue time and consumed by an independent output monitor.
module tb_qs_sort_core;

    localparam int LEN = 10;
    localparam int DW  = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_fg;
    logic [DW-1:0] QS_data_in;
    logic          QS_data_en;
    logic [DW-1:0] QS_data_out;
    logic          idle_fg, done_fg, DIR_fg, DOR_fg;

    int            n_total  = 0;
    int            n_passed = 0;
    logic [DW-1:0] exp_q [$];

    qs_sort_core #(.pDATA_WIDTH(DW), .pLEN(LEN)) dut (
        .wbs_clk_i  (clk),
        .wbs_rst_i  (rst),
        .start_fg   (start_fg),
        .QS_data_in (QS_data_in),
        .QS_data_en (QS_data_en),
        .QS_data_out(QS_data_out),
        .idle_fg    (idle_fg),
        .done_fg    (done_fg),
        .DIR_fg     (DIR_fg),
        .DOR_fg     (DOR_fg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit ref_gt(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef QS_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output monitor: every accepted pop must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (DOR_fg && QS_data_en) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL sb_underflow: got pop of %0h expected none at %0t", QS_data_out, $time);
                end else begin
                    check("pop_data", QS_data_out, exp_q.pop_front());
                end
            end else if (!DOR_fg) begin
                check("out_zero_when_not_ready", QS_data_out, 0);
            end
        end
    end

    task automatic start_job(input int junk, input bit exp_done);
        check("done_before_start", done_fg, exp_done);
        for (int i = 0; i < junk; i++) begin
            QS_data_en = 1'b1;
            QS_data_in = $urandom;
            tick();
        end
        QS_data_en = 1'b0;
        check("idle_ignores_en", idle_fg, 1);
        check("idle_dir_low", DIR_fg, 0);
        start_fg   = 1'b1;
        QS_data_en = 1'b1;
        QS_data_in = 32'hDEADBEEF;
        tick();
        start_fg   = 1'b0;
        QS_data_en = 1'b0;
        check("done_cleared_by_start", done_fg, 0);
        tick();
        check("dir_rise", DIR_fg, 1);
        check("idle_fall", idle_fg, 0);
    endtask

    task automatic run_job(input logic [DW-1:0] w [LEN], input int junk, input bit exp_done);
        logic [DW-1:0] s [LEN];
        int n;
        int popped;
        int guard;
        bit en;

        s = w;
        for (int i = 1; i < LEN; i++) begin
            logic [DW-1:0] key;
            int j;
            key = s[i];
            j = i - 1;
            while (j >= 0) begin
                if (!ref_gt(s[j], key)) break;
                s[j+1] = s[j];
                j--;
            end
            s[j+1] = key;
        end
        foreach (s[i]) exp_q.push_back(s[i]);

        start_job(junk, exp_done);
        for (int i = 0; i < LEN; i++) begin
            while ($urandom_range(0, 3) == 0) begin
                QS_data_en = 1'b0;
                QS_data_in = $urandom;
                start_fg   = 1'($urandom_range(0, 1));
                tick();
            end
            QS_data_en = 1'b1;
            QS_data_in = w[i];
            start_fg   = 1'($urandom_range(0, 1));
            tick();
        end
        QS_data_en = 1'b0;
        start_fg   = 1'b0;

        n = 0;
        while (!DOR_fg && n < 4 * LEN) begin
            QS_data_en = (n < LEN) ? 1'($urandom_range(0, 1)) : 1'b0;
            start_fg   = (n < LEN) ? 1'($urandom_range(0, 1)) : 1'b0;
            QS_data_in = $urandom;
            tick();
            n++;
            if (n == 1) check("dir_fall_after_last_write", DIR_fg, 0);
        end
        QS_data_en = 1'b0;
        start_fg   = 1'b0;
        check("sort_latency", n, LEN + 1);

        popped = 0;
        guard  = 0;
        while (popped < LEN && guard < 8 * LEN) begin
            en         = ($urandom_range(0, 3) != 0);
            QS_data_en = en;
            start_fg   = 1'($urandom_range(0, 1));
            tick();
            guard++;
            if (en) popped++;
        end
        QS_data_en = 1'b0;
        start_fg   = 1'b0;
        tick();
        check("dor_fall", DOR_fg, 0);
        check("done_set", done_fg, 1);
        check("idle_back", idle_fg, 1);
        check("sb_drained", exp_q.size(), 0);
    endtask

    task automatic abort_job(input int nwrites);
        start_job(1, done_fg);
        for (int i = 0; i < nwrites; i++) begin
            QS_data_en = 1'b1;
            QS_data_in = $urandom;
            tick();
        end
        QS_data_en = 1'b0;
        if (nwrites >= LEN) repeat (3) tick();
        #1 rst = 1'b1;
        #1;
        check("abort_idle", idle_fg, 1);
        check("abort_dir", DIR_fg, 0);
        check("abort_dor", DOR_fg, 0);
        check("abort_done", done_fg, 0);
        check("abort_out", QS_data_out, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] w [LEN];

        rst        = 1'b1;
        start_fg   = 1'b0;
        QS_data_en = 1'b0;
        QS_data_in = '0;
        #2;
        check("rst_idle", idle_fg, 1);
        check("rst_done", done_fg, 0);
        check("rst_dir", DIR_fg, 0);
        check("rst_dor", DOR_fg, 0);
        check("rst_out", QS_data_out, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        w = '{32'd9, 32'd3, 32'd7, 32'd1, 32'd8, 32'd2, 32'd6, 32'd0, 32'd5, 32'd4};
        run_job(w, 2, 1'b0);

        w = '{32'd5, 32'd5, 32'hFFFFFFFF, 32'd0, 32'd5, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, 32'd2};
        run_job(w, 0, 1'b1);

        abort_job(4);

        w = '{32'h80000000, 32'd3, 32'hFFFFFFFF, 32'd0, 32'h7FFFFFFF,
              32'h80000001, 32'd1, 32'hFFFFFFFE, 32'd2, 32'h80000000};
        run_job(w, 1, 1'b0);

        abort_job(LEN);

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < LEN; i++)
                w[i] = (t % 2 == 0) ? 32'($urandom_range(0, 7)) : $urandom;
            run_job(w, t % 3, (t == 0) ? 1'b0 : 1'b1);
        end

        repeat (3) tick();
        check("final_sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/qs_sort_core.md
Name: qs_sort_core

Overview:
- Sort engine directly downstream of the Wishbone-to-sorter bridge.
- Accepts a start pulse, then a burst of pLEN words through a single data strobe.
- Sorts them in place with odd-even transposition, then streams them out in ascending order through the same strobe.
- Exposes idle/done/data-in-ready/data-out-ready flags for the bridge's status register (0x000) and read-data ack (0x084).

Parameters:
- pDATA_WIDTH, 32, width of each data word.
- pLEN, 10, number of words per sort job; legal range 2..64.

Ports:
- wbs_clk_i  input  1  sole clock; all state updates on rising edge.
- wbs_rst_i  input  1  reset, asynchronous, active-high.
- start_fg  input  1  job start request; acted on only in IDLE.
- QS_data_in  input  pDATA_WIDTH  write data, sampled when QS_data_en=1 in LOAD.
- QS_data_en  input  1  strobe: push in LOAD, pop in OUT; ignored in other states.
- QS_data_out  output  pDATA_WIDTH  current output word; 0 unless DOR_fg=1.
- idle_fg  output  1  1 in IDLE.
- done_fg  output  1  sticky job-complete flag.
- DIR_fg  output  1  data-in ready, 1 in LOAD.
- DOR_fg  output  1  data-out ready, 1 in OUT.

Behaviour:
- Storage: array of pLEN registers; write index wr_cnt, pass counter pass_cnt, read index rd_cnt.
  - Each counter is $clog2(pLEN)+1 bits.
- Reset, asynchronous:
  - state=IDLE; idle_fg=1; done_fg=0; DIR_fg=0; DOR_fg=0.
  - All counters 0; array cleared to 0; QS_data_out=0.
  - Reset mid-job aborts the job immediately; no partial output.
- Flags are registered from state: idle_fg=(state==IDLE), DIR_fg=(state==LOAD), DOR_fg=(state==OUT).
- IDLE:
  - start_fg=1 -> LOAD next cycle; wr_cnt=0; done_fg cleared.
  - QS_data_en in IDLE is ignored, including a same-cycle start_fg + QS_data_en.
- LOAD:
  - Each cycle with QS_data_en=1: arr[wr_cnt]<=QS_data_in, wr_cnt++.
  - The write with wr_cnt==pLEN-1 stores the word and moves to SORT; pass_cnt=0.
  - start_fg is ignored; a held start strobe is harmless.
- SORT:
  - One pass per cycle. Even pass_cnt compares pairs (0,1),(2,3),…; odd pass_cnt compares pairs (1,2),(3,4),….
  - Swap a pair only if lower-index element > upper-index element (strict), so equal values are never swapped.
  - Comparison is unsigned by default.
  - After exactly pLEN passes -> OUT with rd_cnt=0.
  - Latency: DOR_fg rises pLEN+1 cycles after the cycle carrying the last write.
  - QS_data_en and start_fg are ignored.
- OUT:
  - QS_data_out = arr[rd_cnt], combinationally valid whenever DOR_fg=1.
  - Each cycle with QS_data_en=1: rd_cnt++.
  - The pop with rd_cnt==pLEN-1 -> IDLE; done_fg<=1 on that edge; DOR_fg drops the next cycle.
  - The bridge acks reads combinationally on DOR_fg, so each pop must be a single-cycle strobe. QS_data_en held for k cycles pops k words.
- done_fg stays 1 through IDLE until the next accepted start_fg.
- Only one job in flight; no overlap between LOAD and OUT.

Optional Feature:
- QS_SIGNED_EN defined: compare-swap treats words as two's-complement signed, giving ascending signed order.
- QS_SIGNED_EN undefined: unsigned comparison.
- Nothing else changes: latency, flags and handshake are identical.

Test Plan:
- Basic sort, pLEN=10:
  - Stimulus: start, write 9,3,7,1,8,2,6,0,5,4, then 10 single-cycle pops.
  - Required: reads 0..9 in order; DIR_fg falls after the 10th write.
  - DOR_fg rises exactly 11 cycles after the 10th write; done_fg=1 and idle_fg=1 after the 10th pop.
- Duplicates and extremes:
  - Stimulus: write 5,5,0xFFFFFFFF,0,5,1,1,0,0xFFFFFFFF,2 (unsigned build).
  - Required: reads 0,0,1,1,2,5,5,5,0xFFFFFFFF,0xFFFFFFFF.
- Signed build (QS_SIGNED_EN):
  - Stimulus: write 0x80000000,3,0xFFFFFFFF,0,…
  - Required: 0x80000000 first, 0xFFFFFFFF (-1) before 0.
- Ignored strobes:
  - start_fg during LOAD, SORT and OUT -> no state change.
  - QS_data_en during IDLE and SORT -> array, counters and outputs unchanged.
  - start_fg + QS_data_en in the same IDLE cycle -> LOAD entered, data not stored.
- Reset mid-operation:
  - Assert wbs_rst_i after 4 writes and again during SORT.
  - Required: immediately idle_fg=1 and DIR_fg=DOR_fg=done_fg=0. A following full job sorts correctly with no stale data.
- Back-to-back jobs:
  - Stimulus: second start right after done_fg=1.
  - Required: done_fg clears the next cycle and the second job's output is independent of the first.
